vga_timing_generator: RTL and testbench

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

---
 rtl/vga_timing_generator_pkg.sv | 26 ++
 rtl/vga_timing_generator_if.sv | 21 ++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_generator.sv | 73 +++++++
 tb/tb_vga_timing_generator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_generator_pkg.sv
// Shared VGA timing constants, coordinate type and per-axis phase encoding.
package vga_timing_pkg;

  // Industry-standard 640x480 @ 60 Hz timing.
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  localparam int unsigned CoordWidth = 10;
  localparam int unsigned MaxTotal   = 1 << CoordWidth;

  typedef logic [CoordWidth-1:0] coord_t;

  typedef enum logic [1:0] {
    PhaseActive = 2'd0,
    PhaseFront  = 2'd1,
    PhaseSync   = 2'd2,
    PhaseBack   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_timing_generator_if.sv
// Video timing bundle driven by the generator and consumed by pixel pipelines.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   display_enable;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   line_start;
  logic   frame_start;

  modport master (
    output hsync, vsync, display_enable, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, display_enable, pixel_x, pixel_y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned visible = DefHVisible,
  parameter int unsigned front   = DefHFront,
  parameter int unsigned sync    = DefHSync,
  parameter int unsigned back    = DefHBack
) (
  input  logic   pixel_clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output phase_e phase,
  output logic   wrap
);

  localparam int unsigned Total = visible + front + sync + back;

  if (visible == 0 || front == 0 || sync == 0 || back == 0) begin : g_bad_phase
    $error("vga_axis_counter: every phase needs at least one count");
  end

  localparam coord_t LastCount  = coord_t'(Total - 1);
  localparam coord_t FrontStart = coord_t'(visible);
  localparam coord_t SyncStart  = coord_t'(visible + front);
  localparam coord_t BackStart  = coord_t'(visible + front + sync);

  coord_t count_q, count_d;
  phase_e phase_q, phase_d;

  assign wrap = advance && (count_q == LastCount);

  // Phase follows the count it will hold next, so both registers always agree.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance) begin
      count_d = wrap ? '0 : count_q + coord_t'(1);
      unique case (phase_q)
        PhaseActive: if (count_d == FrontStart) phase_d = PhaseFront;
        PhaseFront:  if (count_d == SyncStart)  phase_d = PhaseSync;
        PhaseSync:   if (count_d == BackStart)  phase_d = PhaseBack;
        PhaseBack:   if (wrap)                  phase_d = PhaseActive;
      endcase
    end
  end

  // Reset parks the axis on its last count so the first edge lands on 0/ACTIVE.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      count_q <= LastCount;
      phase_q <= PhaseBack;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA sync/position generator: horizontal axis free-runs, vertical axis steps on line wrap.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = DefHVisible,
  parameter int unsigned H_FRONT         = DefHFront,
  parameter int unsigned H_SYNC          = DefHSync,
  parameter int unsigned H_BACK          = DefHBack,
  parameter int unsigned V_VISIBLE       = DefVVisible,
  parameter int unsigned V_FRONT         = DefVFront,
  parameter int unsigned V_SYNC          = DefVSync,
  parameter int unsigned V_BACK          = DefVBack,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               reset,
  vga_timing_if.master       vid
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MaxTotal || V_TOTAL > MaxTotal) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL and V_TOTAL must not exceed %0d", MaxTotal);
  end

  coord_t h_count, v_count;
  phase_e h_phase, v_phase;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(
    .visible (H_VISIBLE),
    .front   (H_FRONT),
    .sync    (H_SYNC),
    .back    (H_BACK)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .advance   (1'b1),
    .count     (h_count),
    .phase     (h_phase),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .visible (V_VISIBLE),
    .front   (V_FRONT),
    .sync    (V_SYNC),
    .back    (V_BACK)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .advance   (h_wrap),
    .count     (v_count),
    .phase     (v_phase),
    .wrap      (v_wrap)
  );

  // A frame can only end on the last pixel of a line.
  a_frame_wrap_on_line_wrap : assert property (
    @(posedge pixel_clk) disable iff (reset) v_wrap |-> h_wrap
  );

  // Every output decodes only the axis state registers, so all refer to one position.
  assign vid.pixel_x        = h_count;
  assign vid.pixel_y        = v_count;
  assign vid.display_enable = (h_phase == PhaseActive) && (v_phase == PhaseActive);
  assign vid.hsync          = (h_phase == PhaseSync) ^ SYNC_ACTIVE_LOW;
  assign vid.vsync          = (v_phase == PhaseSync) ^ SYNC_ACTIVE_LOW;
  assign vid.line_start     = (h_count == '0);
  assign vid.frame_start    = (h_count == '0) && (v_count == '0);

endmodule

// File: tb/tb_vga_timing_generator.sv
// Checks default, scaled and tiny VGA timings against an arithmetic position model.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vid_def ();
  vga_timing_if vid_med ();
  vga_timing_if vid_sml ();

  vga_timing_generator u_def (
    .pixel_clk (clk),
    .reset     (rst),
    .vid       (vid_def)
  );

  vga_timing_generator #(
    .H_VISIBLE (40), .H_FRONT (4), .H_SYNC (4), .H_BACK (2),
    .V_VISIBLE (24), .V_FRONT (3), .V_SYNC (2), .V_BACK (4),
    .SYNC_ACTIVE_LOW (1'b1)
  ) u_med (
    .pixel_clk (clk),
    .reset     (rst),
    .vid       (vid_med)
  );

  vga_timing_generator #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (1),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_ACTIVE_LOW (1'b0)
  ) u_sml (
    .pixel_clk (clk),
    .reset     (rst),
    .vid       (vid_sml)
  );

  typedef struct {
    int n; int x; int y; bit de; bit ls; bit fs; bit hs; bit vs;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  longint cnt = -1;   // cycles since reset release; -1 while in reset
  longint cyc = 0;
  bit     stats_on = 1'b0;

  int h_low = 0, h_first = -1, de_line = 0;
  int m_vlow = 0, m_vfx = -1, m_vfy = -1, m_de = 0;
  int s_hhigh = 0, s_vhigh = 0, s_de = 0;
  longint last_ls = -1, last_fs_med = -1, last_fs_sml = -1;

  // Expected outputs straight from the timing rules: position from elapsed cycles.
  function automatic logic [24:0] model(input int id, input longint c);
    int hv, hf, hs, hb, vv, vf, vs, vb, ht, vt;
    bit low, de, ls, fs, hsa, vsa;
    longint x, y;
    case (id)
      0: begin hv = 640; hf = 16; hs = 96; hb = 48; vv = 480; vf = 10; vs = 2; vb = 33; low = 1; end
      1: begin hv = 40; hf = 4; hs = 4; hb = 2; vv = 24; vf = 3; vs = 2; vb = 4; low = 1; end
      default: begin hv = 8; hf = 2; hs = 3; hb = 1; vv = 4; vf = 1; vs = 1; vb = 1; low = 0; end
    endcase
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (c < 0) begin
      x = ht - 1; y = vt - 1; de = 0; ls = 0; fs = 0; hsa = 0; vsa = 0;
    end else begin
      x   = c % ht;
      y   = (c / ht) % vt;
      de  = (x < hv) && (y < vv);
      ls  = (x == 0);
      fs  = (x == 0) && (y == 0);
      hsa = (x >= hv + hf) && (x < hv + hf + hs);
      vsa = (y >= vv + vf) && (y < vv + vf + vs);
    end
    return {10'(x), 10'(y), de, ls, fs, hsa ^ low, vsa ^ low};
  endfunction

  function automatic logic [24:0] actual(input int id);
    case (id)
      0: return {vid_def.pixel_x, vid_def.pixel_y, vid_def.display_enable, vid_def.line_start,
                 vid_def.frame_start, vid_def.hsync, vid_def.vsync};
      1: return {vid_med.pixel_x, vid_med.pixel_y, vid_med.display_enable, vid_med.line_start,
                 vid_med.frame_start, vid_med.hsync, vid_med.vsync};
      default: return {vid_sml.pixel_x, vid_sml.pixel_y, vid_sml.display_enable,
                       vid_sml.line_start, vid_sml.frame_start, vid_sml.hsync, vid_sml.vsync};
    endcase
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got x=%0d y=%0d de,ls,fs,hs,vs=%b required x=%0d y=%0d de,ls,fs,hs,vs=%b",
               name, cyc, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int id = 0; id < 3; id++) check($sformatf("%s inst%0d", tag, id), actual(id), model(id, cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) cnt++;
    check_all("cycle");
    if (stats_on && cnt >= 0) begin
      if (cnt < 800) begin
        if (vid_def.hsync == 1'b0) begin
          if (h_low == 0) h_first = int'(vid_def.pixel_x);
          h_low++;
        end
        if (vid_def.display_enable) de_line++;
      end
      if (cnt < 1650) begin
        if (vid_med.vsync == 1'b0) begin
          if (m_vlow == 0) begin m_vfx = int'(vid_med.pixel_x); m_vfy = int'(vid_med.pixel_y); end
          m_vlow++;
        end
        if (vid_med.display_enable) m_de++;
      end
      if (cnt < 14 && vid_sml.hsync) s_hhigh++;
      if (cnt < 98) begin
        if (vid_sml.vsync) s_vhigh++;
        if (vid_sml.display_enable) s_de++;
      end
    end
    if (vid_def.line_start) begin
      if (last_ls >= 0) check_int("line_start period", cyc - last_ls, 800);
      last_ls = cyc;
    end
    if (vid_med.frame_start) begin
      if (last_fs_med >= 0) check_int("med frame_start period", cyc - last_fs_med, 1650);
      last_fs_med = cyc;
    end
    if (vid_sml.frame_start) begin
      if (last_fs_sml >= 0) check_int("sml frame_start period", cyc - last_fs_sml, 98);
      last_fs_sml = cyc;
    end
  endtask

  // Called just after an edge; reset takes effect without waiting for a clock.
  task automatic assert_reset();
    rst = 1'b1;
    cnt = -1;
    last_ls = -1; last_fs_med = -1; last_fs_sml = -1;
    #1;
    check_all("async reset");
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   tbl [12];
    longint base;

    tbl[0]  = '{0,    0,   0,  1, 1, 1, 1, 1};
    tbl[1]  = '{1,    1,   0,  1, 0, 0, 1, 1};
    tbl[2]  = '{639,  639, 0,  1, 0, 0, 1, 1};
    tbl[3]  = '{640,  640, 0,  0, 0, 0, 1, 1};
    tbl[4]  = '{655,  655, 0,  0, 0, 0, 1, 1};
    tbl[5]  = '{656,  656, 0,  0, 0, 0, 0, 1};
    tbl[6]  = '{751,  751, 0,  0, 0, 0, 0, 1};
    tbl[7]  = '{752,  752, 0,  0, 0, 0, 1, 1};
    tbl[8]  = '{799,  799, 0,  0, 0, 0, 1, 1};
    tbl[9]  = '{800,  0,   1,  1, 1, 0, 1, 1};
    tbl[10] = '{1456, 656, 1,  0, 0, 0, 0, 1};
    tbl[11] = '{8000, 0,   10, 1, 1, 0, 1, 1};

    // Reset held: values parked at the end of the frame.
    repeat (3) step();
    check_int("reset pixel_x", vid_def.pixel_x, 799);
    check_int("reset pixel_y", vid_def.pixel_y, 524);
    check_int("reset hsync", vid_def.hsync, 1);
    check_int("reset sml vsync", vid_sml.vsync, 0);

    rst = 1'b0;
    stats_on = 1'b1;
    step();
    check_int("release frame_start", vid_def.frame_start, 1);
    check_int("release display_enable", vid_def.display_enable, 1);

    for (int i = 0; i < 12; i++) begin
      while (cnt < tbl[i].n) step();
      check($sformatf("table n=%0d", tbl[i].n), actual(0),
            {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].hs, tbl[i].vs});
    end
    stats_on = 1'b0;

    check_int("def hsync low cycles", h_low, 96);
    check_int("def hsync first x", h_first, 656);
    check_int("def de per line", de_line, 640);
    check_int("med vsync low cycles", m_vlow, 100);
    check_int("med vsync first x", m_vfx, 0);
    check_int("med vsync first y", m_vfy, 27);
    check_int("med de per frame", m_de, 960);
    check_int("sml hsync high cycles", s_hhigh, 3);
    check_int("sml vsync high cycles", s_vhigh, 14);
    check_int("sml de per frame", s_de, 32);

    // Row and frame wraps on the scaled instance.
    base = (cnt / 1650 + 1) * 1650;
    while (cnt < base + 23 * 50) step();
    check_int("med last row de", vid_med.display_enable, 1);
    while (cnt < base + 23 * 50 + 49) step();
    check_int("med row wrap x", vid_med.pixel_x, 49);
    step();
    check_int("med row wrap y", vid_med.pixel_y, 24);
    check_int("med de falls", vid_med.display_enable, 0);
    while (cnt < base + 1649) step();
    check_int("med frame end y", vid_med.pixel_y, 32);
    step();
    check_int("med frame wrap x", vid_med.pixel_x, 0);
    check_int("med frame wrap fs", vid_med.frame_start, 1);

    // Mid-frame reset at (30,20).
    base = cnt;
    while (cnt < base + 20 * 50 + 30) step();
    assert_reset();
    check_int("midreset med x", vid_med.pixel_x, 49);
    check_int("midreset med y", vid_med.pixel_y, 32);
    check_int("midreset def y", vid_def.pixel_y, 524);
    repeat (3) step();
    rst = 1'b0;
    step();
    check_int("restart med x", vid_med.pixel_x, 0);
    check_int("restart med fs", vid_med.frame_start, 1);

    // Random run lengths and reset pulses.
    for (int k = 0; k < 25; k++) begin
      int run_len = int'($urandom_range(20, 2500));
      int rst_len = int'($urandom_range(1, 4));
      repeat (run_len) step();
      assert_reset();
      repeat (rst_len) step();
      rst = 1'b0;
    end
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
